divider: RTL and testbench

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the execute stage's M-extension unit, beside the multiplier.
- Uses the same level-held request / done-pulse handshake as the multiplier.
- Signed operands are converted to magnitudes on entry; signs are fixed on the output.

---
 rtl/divider_if.sv | 27 ++
 rtl/divider.sv | 150 +++++++++++++++
 tb/tb_divider.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// divider_if: request/response bundle between the M-extension unit and the divider.
//   rs1_data, rs2_data : dividend and divisor, sampled on the start cycle
//   funct3             : 100 div, 101 divu, 110 rem, 111 remu
//   is_div             : level request, held high until div_done
//   div_done           : one-cycle completion pulse
//   div_out            : quotient or remainder, valid while div_done is high
// The master modport is the pipeline side; the slave modport is the divider.
interface divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [2:0]       funct3;
  logic             is_div;
  logic             div_done;
  logic [WIDTH-1:0] div_out;

  modport master (
    output rs1_data, rs2_data, funct3, is_div,
    input  div_done, div_out
  );

  modport slave (
    input  rs1_data, rs2_data, funct3, is_div,
    output div_done, div_out
  );
endinterface

// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : divider_if.slave (operands, funct3, is_div request, div_done, div_out)
// Signed operands are converted to magnitudes at the start cycle. WIDTH
// restoring steps follow, then div_out applies the saved sign. Divide by zero
// and signed overflow are resolved at the start cycle and finish one cycle later.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  localparam int              CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CNT_W-1:0] count_reg;
  logic             rem_sel_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  // Start-cycle decode, evaluated on the live inputs.
  logic             is_signed;
  logic             rs1_neg;
  logic             rs2_neg;
  logic [WIDTH-1:0] rs1_mag;
  logic [WIDTH-1:0] rs2_mag;
  logic             div_by_zero;
  logic             overflow;
  logic             special;
  logic             start;

  // Only the signed encodings (div=100, rem=110) take the magnitude path.
  assign is_signed   = bus.funct3[2] & ~bus.funct3[0];
  assign rs1_neg     = is_signed & bus.rs1_data[WIDTH-1];
  assign rs2_neg     = is_signed & bus.rs2_data[WIDTH-1];
  assign rs1_mag     = rs1_neg ? -bus.rs1_data : bus.rs1_data;
  assign rs2_mag     = rs2_neg ? -bus.rs2_data : bus.rs2_data;
  assign div_by_zero = (bus.rs2_data == '0);
  assign overflow    = is_signed & (bus.rs1_data == MIN_NEG) & (bus.rs2_data == '1);
  assign special     = div_by_zero | overflow;
  assign start       = (state_reg == IDLE) & bus.is_div;

  // One restoring step: shift {rem,quo} left, try subtracting the divisor.
  // The partial remainder can reach 2*divisor-1, so the trial needs one extra bit;
  // its top bit set means the subtraction borrowed and must be discarded.
  logic [WIDTH:0] trial;
  logic           trial_ok;

  assign trial    = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, divisor_reg};
  assign trial_ok = ~trial[WIDTH];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and handshake output
  always_comb begin
    state_next   = state_reg;
    bus.div_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.is_div) begin
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        // Dropping the request mid-calculation abandons the operation silently.
        if (!bus.is_div) begin
          state_next = IDLE;
        end else if (count_reg == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.div_done = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_reg     <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      count_reg   <= '0;
      rem_sel_reg <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
    end else if (start) begin
      rem_sel_reg <= bus.funct3[1];
      divisor_reg <= rs2_mag;
      count_reg   <= '0;
      if (div_by_zero) begin
        // Quotient all ones, remainder is the raw dividend, no sign fix-up.
        quo_reg   <= '1;
        rem_reg   <= bus.rs1_data;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else if (overflow) begin
        quo_reg   <= MIN_NEG;
        rem_reg   <= '0;
        neg_q_reg <= 1'b0;
        neg_r_reg <= 1'b0;
      end else begin
        quo_reg   <= rs1_mag;
        rem_reg   <= '0;
        neg_q_reg <= rs1_neg ^ rs2_neg;
        neg_r_reg <= rs1_neg;
      end
    end else if (state_reg == CALC) begin
      // The dividend lives in quo_reg and shifts out of its top as quotient bits shift in.
      quo_reg   <= {quo_reg[WIDTH-2:0], trial_ok};
      rem_reg   <= trial_ok ? trial[WIDTH-1:0] : {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Result select and sign fix-up from held registers; stays valid until the next start.
  logic [WIDTH-1:0] result_mag;
  logic             result_neg;

  assign result_mag  = rem_sel_reg ? rem_reg : quo_reg;
  assign result_neg  = rem_sel_reg ? neg_r_reg : neg_q_reg;
  assign bus.div_out = result_neg ? -result_mag : result_mag;

endmodule

// File: tb/tb_divider.sv
// tb_divider: self-checking bench for divider. Directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;
  localparam int TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  divider_if #(.WIDTH(W)) bus ();

  divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference result from RISC-V M-extension rules in plain arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [2:0] f3, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint r;
    if (b == '0) return f3[1] ? a : '1;
    if (!f3[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = f3[1] ? (sa % sb) : (sa / sb);
      return r[W-1:0];
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  // Cycles from start cycle to the div_done cycle.
  function automatic int ref_latency(input logic [2:0] f3, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    if (b == '0) return 1;
    if (!f3[0] && a == MIN_NEG && b == '1) return 1;
    return W + 1;
  endfunction

  // Drive one operation (called just after a falling edge) and check it.
  // extra: idle cycles expected before the start cycle (1 for a chained request).
  // hold:  leave is_div high after div_done to chain the next operation.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int extra, input bit hold);
    logic [W-1:0] exp;
    int elat;
    int lat;
    exp  = ref_result(f3, a, b);
    elat = ref_latency(f3, a, b) + extra;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.is_div   = 1'b1;
    lat = 0;
    while (lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      if (bus.div_done) break;
      // Operands are no longer looked at once the start cycle has passed.
      if (lat == extra + 1) begin
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
        bus.funct3   = {1'b1, 2'($urandom_range(0, 3))};
      end
    end
    check({tag, "_lat"}, W'(lat), W'(elat));
    check({tag, "_out"}, bus.div_out, exp);
    $display("op %s f3=%03b a=0x%08h b=0x%08h out=0x%08h lat=%0d", tag, f3, a, b, bus.div_out, lat);
    if (!hold) begin
      bus.is_div = 1'b0;
      @(negedge clk);
      check({tag, "_pulse"}, W'(bus.div_done), W'(0));
      check({tag, "_hold"}, bus.div_out, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return MIN_NEG;
      2:       return '1;
      3:       return W'($urandom_range(0, 20));
      4:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    logic [2:0] f3;

    rst          = 1'b1;
    bus.is_div   = 1'b0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.funct3   = 3'b100;

    repeat (2) @(negedge clk);
    check("reset_done", W'(bus.div_done), W'(0));
    check("reset_out", bus.div_out, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_done", W'(bus.div_done), W'(0));

    // Directed cases
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 0, 0);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 0, 0);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 0, 0);
    run_op("divu_dz",    3'b101, 32'h1234, 32'd0, 0, 0);
    run_op("rem_dz",     3'b110, 32'h1234, 32'd0, 0, 0);
    run_op("div_ovf",    3'b100, MIN_NEG, 32'hFFFF_FFFF, 0, 0);
    run_op("rem_ovf",    3'b110, MIN_NEG, 32'hFFFF_FFFF, 0, 0);

    // Back-to-back: request still high in the IDLE cycle after DONE.
    run_op("b2b_first",  3'b101, 32'd1000, 32'd9, 0, 1);
    run_op("b2b_second", 3'b110, 32'hFFFF_FC18, 32'd7, 1, 0);
    run_op("b2b_dz_a",   3'b100, 32'd5, 32'd0, 0, 1);
    run_op("b2b_dz_b",   3'b111, 32'd5, 32'd0, 1, 0);

    // Abort: drop the request ten cycles into the calculation.
    bus.funct3   = 3'b100;
    bus.rs1_data = 32'd1000;
    bus.rs2_data = 32'd7;
    bus.is_div   = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.div_done) seen = 1'b1;
    end
    bus.is_div = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done) seen = 1'b1;
    end
    check("abort_no_done", W'(seen), W'(0));
    $display("op abort no_done_seen=%0d", seen);
    run_op("abort_restart", 3'b101, 32'hFFFF_FFFF, 32'd1, 0, 0);

    // Asynchronous reset in the middle of a calculation.
    bus.funct3   = 3'b101;
    bus.rs1_data = 32'hFFFF_FFFF;
    bus.rs2_data = 32'd3;
    bus.is_div   = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_done", W'(bus.div_done), W'(0));
    check("rst_mid_out", bus.div_out, '0);
    $display("op reset_mid_calc done=%0d out=0x%08h", bus.div_done, bus.div_out);
    @(negedge clk);
    bus.is_div = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    run_op("rst_divu_9_3", 3'b101, 32'd9, 32'd3, 0, 0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      run_op($sformatf("rand%0d", i), f3, rand_operand(), rand_operand(), 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
